// File: rtl/ccm_block_pack.sv
`default_nettype none
// ============================================================================
// Module   : ccm_block_pack
// Brief    : Packs the 8-bit CCM byte stream into zero-padded 128-bit blocks,
//            first byte in the MSB, queued in a 2-entry valid/ready buffer.
// Revision : 1.0 - initial release
// ============================================================================
module ccm_block_pack #(
  parameter int WIDTH       = 8,
  parameter int WIDTH_BLOCK = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       input_data,
  input  logic                   input_en,
  input  logic                   input_last,
  output logic [WIDTH_BLOCK-1:0] block_data,
  output logic [4:0]             block_bytes,
  output logic                   block_last,
  output logic                   block_valid,
  input  logic                   block_ready,
  output logic                   overflow
);

  localparam int         c_BYTES = WIDTH_BLOCK / WIDTH;
  localparam logic [3:0] c_LAST_SLOT = 4'(c_BYTES - 1);
  localparam logic [4:0] c_FULL_BYTES = 5'(c_BYTES);

  logic [WIDTH_BLOCK-1:0] r_asm;
  logic [3:0]             r_cnt;
  logic [WIDTH_BLOCK-1:0] r_mem_data  [2];
  logic [4:0]             r_mem_bytes [2];
  logic                   r_mem_last  [2];
  logic                   r_wptr;
  logic                   r_rptr;
  logic [1:0]             r_occ;
  logic                   r_overflow;
  // r_prev_in_buf: the most recent commit actually landed in the buffer.
  logic                   r_prev_in_buf;
  logic                   r_prev_last;

  logic [3:0]             w_slot;
  logic [WIDTH_BLOCK-1:0] w_lane;
  logic [WIDTH_BLOCK-1:0] w_asm;
  logic [4:0]             w_held;
  logic                   w_full_commit;
  logic                   w_part_commit;
  logic                   w_empty_last;
  logic                   w_pop;
  logic                   w_youngest_live;
  logic                   w_mark;
  logic                   w_term;
  logic                   w_push;
  logic [WIDTH_BLOCK-1:0] w_push_data;
  logic [4:0]             w_push_bytes;
  logic                   w_push_last;
  logic                   w_room;
  logic                   w_push_ok;
  logic                   w_drop;

  // Byte lane placement assumes WIDTH == 8 (slot index times 8).
  assign w_slot = c_LAST_SLOT - r_cnt;
  assign w_lane = WIDTH_BLOCK'(input_data) << {w_slot, 3'b000};
  assign w_asm  = input_en ? (r_asm | w_lane) : r_asm;
  assign w_held = {1'b0, r_cnt} + {4'b0000, input_en};

  assign w_full_commit = input_en && (r_cnt == c_LAST_SLOT);
  assign w_part_commit = input_last && !w_full_commit && (w_held != 5'd0);
  assign w_empty_last  = input_last && (r_cnt == 4'd0) && !input_en;

  assign w_pop = (r_occ != 2'd0) && block_ready;

  // The youngest entry can still be re-tagged only if it holds the latest
  // commit and survives this cycle's pop.
  assign w_youngest_live = r_prev_in_buf && (r_occ != 2'd0) && !(w_pop && (r_occ == 2'd1));
  assign w_mark = w_empty_last && !r_prev_last && w_youngest_live;
  assign w_term = w_empty_last && !r_prev_last && !w_youngest_live;

  assign w_push       = w_full_commit || w_part_commit || w_term;
  assign w_push_data  = w_term ? '0 : w_asm;
  assign w_push_bytes = w_full_commit ? c_FULL_BYTES : (w_part_commit ? w_held : 5'd0);
  assign w_push_last  = w_full_commit ? input_last : 1'b1;

  assign w_room    = (r_occ != 2'd2) || w_pop;
  assign w_push_ok = w_push && w_room;
  assign w_drop    = w_push && !w_room;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_asm         <= '0;
      r_cnt         <= '0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      r_occ         <= '0;
      r_overflow    <= 1'b0;
      r_prev_in_buf <= 1'b0;
      r_prev_last   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_mem_data[i]  <= '0;
        r_mem_bytes[i] <= '0;
        r_mem_last[i]  <= 1'b0;
      end
    end else begin
      if (w_full_commit || w_part_commit) begin
        r_asm <= '0;
        r_cnt <= '0;
      end else if (input_en) begin
        r_asm <= w_asm;
        r_cnt <= r_cnt + 4'd1;
      end

      if (w_push_ok) begin
        r_mem_data[r_wptr]  <= w_push_data;
        r_mem_bytes[r_wptr] <= w_push_bytes;
        r_mem_last[r_wptr]  <= w_push_last;
        r_wptr              <= ~r_wptr;
      end

      if (w_mark) begin
        r_mem_last[~r_wptr] <= 1'b1;
      end

      if (w_push) begin
        r_prev_in_buf <= w_push_ok;
        r_prev_last   <= w_push_last;
      end else if (w_mark) begin
        r_prev_last <= 1'b1;
      end

      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end

      r_occ <= r_occ + {1'b0, w_push_ok} - {1'b0, w_pop};

      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign block_data  = r_mem_data[r_rptr];
  assign block_bytes = r_mem_bytes[r_rptr];
  assign block_last  = r_mem_last[r_rptr];
  assign block_valid = (r_occ != 2'd0);
  assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: doc/ccm_block_pack.md
# ccm_block_pack

Receive-side byte-to-block packer for the CCM datapath. It consumes the 8-bit byte stream produced by `ccm_ctr` or the data source (`*_data` / `*_en` / `*_last` strobes) and assembles 128-bit AES blocks. The first byte received goes in the MSB, and partial blocks are zero-padded. Assembled blocks are queued in a 2-entry buffer and handed to the downstream AES / CBC-MAC stage over a valid/ready handshake.

## Interface
- `WIDTH`, 8, byte width of the input stream (fixed at 8; other values are unsupported).
- `WIDTH_BLOCK`, 128, output block width; holds `WIDTH_BLOCK/WIDTH` = 16 bytes per block.
- `clk` input 1: single clock, all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `input_data` input 8: stream byte, sampled when `input_en`=1.
- `input_en` input 1: byte-valid strobe. No backpressure to the source.
- `input_last` input 1: one-cycle end-of-message strobe. It may coincide with the final `input_en` or arrive on any later cycle before the next message's first byte.
- `block_data` output 128: head block. Byte k of the block is at bits [127-8k : 120-8k]; unused bytes are 0.
- `block_bytes` output 5: number of valid bytes in the head block, 0..16.
- `block_last` output 1: head block ends the message.
- `block_valid` output 1: head block present.
- `block_ready` input 1: consumer accepts the head block when `block_valid & block_ready`.
- `overflow` output 1: sticky; a block was dropped because the buffer was full.

## Operation
**Assembly register**
- 128-bit assembly register plus a byte counter `cnt`, 0..15.
- On `input_en`, the byte is written at index `cnt` and `cnt` increments.

**Commit** (push to the buffer), on any of:
- 16th byte received (`cnt`=15 with `input_en`): `block_bytes`=16, last = `input_last` that cycle. Then `cnt`←0 and the assembly register is cleared.
- `input_last` with `cnt`+`input_en` > 0 and the block not full: push a partial block with zero padding, `block_bytes` = bytes held, last=1. Then clear.

**`input_last` with no bytes held** (`cnt`=0, `input_en`=0):
- If the youngest buffer entry was the most recent commit, is still unpopped, and has last=0: set its last flag. No new push.
- If that entry is being popped in the same cycle, or the buffer is empty: push a terminator block with `block_bytes`=0, data all zeros, last=1.
- If the previous commit already had last=1: ignore.

**Buffer**
- 2-entry FIFO: 1-bit read/write pointers and an occupancy counter, 0..2.
- Push and pop in the same cycle are both performed, including when full: the pop frees the slot.
- Push while full without a pop: the block is dropped, `overflow`←1, and the assembly register still clears.

**Outputs**
- `block_valid` = occupancy ≠ 0.
- `block_data`, `block_bytes` and `block_last` come from the head entry and are stable while `block_valid & !block_ready`.

**Reset**
- Clears `cnt`, the assembly register, both buffer entries, the pointers, the occupancy counter and `overflow`.
- A message in flight is discarded. The first byte after reset lands at index 0.

## Timing
- Reset values: `block_valid`=0, `block_data`=0, `block_bytes`=0, `block_last`=0, `overflow`=0.
- Latency: a commit triggered at rising edge N gives `block_valid`=1 after edge N (1 cycle), when the buffer was empty.
- Back-to-back input bytes are sustained indefinitely when the consumer pops at least once every 16 cycles.
- `overflow` asserts on the edge of the dropped push and holds until `reset`.
- No combinational path from `input_*` to `block_*`. `block_ready` affects only the next-cycle state.

## Test plan
1. **Two full blocks, last on the final byte.**
   - Stimulus: 32 bytes 0x00..0x1F back-to-back, `input_last` with byte 0x1F, `block_ready`=1.
   - Required: block 0x000102…0F with bytes=16, last=0; then block 0x1011…1F with bytes=16, last=1.
2. **Partial final block, delayed last.**
   - Stimulus: 34 bytes 0x00..0x21, `input_last` one cycle after the last `input_en`.
   - Required: third block = 0x2021 followed by 14 zero bytes, bytes=2, last=1, `block_valid` 1 cycle after the `input_last` edge.
3. **Late last, block held.**
   - Stimulus: 16 bytes 0xA0..0xAF with `block_ready`=0, `input_last` 3 cycles later, then `block_ready`=1.
   - Required: exactly one block, bytes=16, last=1.
4. **Late last, block already consumed.**
   - Stimulus: same as scenario 3 but with `block_ready`=1 throughout.
   - Required: data block with last=0, then a terminator block with bytes=0, data=0, last=1.
5. **Overflow.**
   - Stimulus: `block_ready`=0, 48 bytes streamed.
   - Required: `overflow`=1 the cycle after byte 48. Raising `block_ready` then yields only blocks 0 and 1, unchanged.
   - Follow-up: simultaneous push/pop while full (`block_ready`=1) must not set `overflow`.
6. **Reset mid-block.**
   - Stimulus: 5 bytes 0x11, `reset` for 1 cycle, then 16 bytes 0x00..0x0F with last.
   - Required: a single block 0x0001…0F, bytes=16, last=1, with no trace of 0x11; `overflow`=0.
